// File: rtl/imager_sensor_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : imager_sensor_emulator
//  Purpose  : Sensor-side emulator. Follows XVS/XHS/XTRIG from the sync/trigger
//             generator and returns synthetic pixel lines as 160-bit words
//             (16 x 10-bit pixels) with a valid strobe and active-line index.
//  Revision : 1.0 - initial release
// ============================================================================
module imager_sensor_emulator #(
    parameter int PIX_W        = 10,
    parameter int PIX_PER_WORD = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          enable,
    input  logic                          trigMode,
    input  logic                          XVS,
    input  logic                          XHS,
    input  logic                          XTRIG,
    input  logic [11:0]                   lineWidth,
    input  logic [15:0]                   startLine,
    input  logic [15:0]                   numLines,
    input  logic [1:0]                    patternSel,
    output logic [PIX_W*PIX_PER_WORD-1:0] pixData,
    output logic                          pixVld,
    output logic [12:0]                   currentLine,
    output logic                          frameDone,
    output logic [15:0]                   frameCnt,
    output logic [15:0]                   ovflCnt
);

    localparam int         c_DATA_W    = PIX_W * PIX_PER_WORD;
    localparam logic [15:0] c_OVFL_MAX = 16'hFFFF;
    // Sync lanes are {XTRIG, XHS, XVS}; each lane resets to its inactive level
    localparam logic [2:0] c_SYNC_RST  = 3'b011;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_LINE = 2'd1;
    localparam logic [1:0] c_EMIT      = 2'd2;
    localparam logic [1:0] c_FRAME_END = 2'd3;

    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [2:0]                  r_sync_d;
    logic [2:0]                  w_sync;
    logic                        w_vs_fall;
    logic                        w_hs_fall;
    logic                        w_trig_rise;
    logic                        w_arm_edge;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic [16:0] r_line_cnt;
    logic [11:0] r_word_cnt;
    logic [11:0] r_line_width;
    logic [15:0] r_start_line;
    logic [15:0] r_num_lines;
    logic [1:0]  r_pat_sel;

    logic [16:0] w_line_end;
    logic [12:0] w_line_idx;
    logic        w_words_left;
    logic        w_last_word;

    logic        w_arm;
    logic        w_abort;
    logic        w_line_skip;
    logic        w_line_start;
    logic        w_emit;
    logic        w_overrun;
    logic        w_frame_done;

    logic [11:0]       w_word_idx;
    logic [PIX_W-1:0]  w_pat_line;
    logic [1:0]        w_pat_sel;
    logic [PIX_W-1:0]  w_pix_base;
    logic [c_DATA_W-1:0] w_pix_word;

    // Metastability chains for the three asynchronous sync inputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync   <= {SYNC_STAGES{c_SYNC_RST}};
            r_sync_d <= c_SYNC_RST;
        end else begin
            r_sync[0] <= {XTRIG, XHS, XVS};
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign w_vs_fall   = r_sync_d[0] & ~w_sync[0];
    assign w_hs_fall   = r_sync_d[1] & ~w_sync[1];
    assign w_trig_rise = ~r_sync_d[2] & w_sync[2];
    assign w_arm_edge  = trigMode ? w_trig_rise : w_vs_fall;

    // 17-bit sum so the active window end never wraps
    assign w_line_end   = {1'b0, r_start_line} + {1'b0, r_num_lines};
    assign w_line_idx   = 13'(r_line_cnt - {1'b0, r_start_line});
    assign w_words_left = (r_word_cnt < r_line_width);
    assign w_last_word  = ((r_word_cnt + 12'd1) == r_line_width);

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and per-cycle action decode; arming edge beats XHS edge
    always_comb begin
        w_state_nxt  = r_state;
        w_arm        = 1'b0;
        w_abort      = 1'b0;
        w_line_skip  = 1'b0;
        w_line_start = 1'b0;
        w_emit       = 1'b0;
        w_overrun    = 1'b0;
        w_frame_done = 1'b0;
        if (!enable) begin
            w_state_nxt = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_arm_edge) begin
                        w_arm       = 1'b1;
                        w_state_nxt = c_WAIT_LINE;
                    end
                end
                c_WAIT_LINE, c_EMIT: begin
                    if (w_arm_edge) begin
                        w_arm       = 1'b1;
                        w_abort     = 1'b1;
                        w_state_nxt = c_WAIT_LINE;
                    end else if (w_hs_fall) begin
                        // In EMIT with words outstanding this is a line overrun
                        w_overrun = (r_state == c_EMIT) && w_words_left;
                        if (r_line_cnt < {1'b0, r_start_line}) begin
                            w_line_skip = 1'b1;
                            w_state_nxt = c_WAIT_LINE;
                        end else if (r_line_cnt < w_line_end) begin
                            w_line_start = 1'b1;
                            if (r_state == c_EMIT) begin
                                // Overrun restart: one idle cycle before word 0
                                w_state_nxt = (r_line_width == 12'd0) ? c_WAIT_LINE : c_EMIT;
                            end else if (r_line_width == 12'd0) begin
                                w_state_nxt = c_WAIT_LINE;
                            end else begin
                                w_emit      = 1'b1;
                                w_state_nxt = (r_line_width == 12'd1) ? c_WAIT_LINE : c_EMIT;
                            end
                        end else begin
                            w_state_nxt = c_FRAME_END;
                        end
                    end else if (r_state == c_EMIT) begin
                        if (w_words_left) begin
                            w_emit = 1'b1;
                            if (w_last_word) begin
                                w_state_nxt = c_WAIT_LINE;
                            end
                        end else begin
                            w_state_nxt = c_WAIT_LINE;
                        end
                    end
                end
                c_FRAME_END: begin
                    // Frame is complete; an arming edge here starts the next one
                    w_frame_done = 1'b1;
                    if (w_arm_edge) begin
                        w_arm       = 1'b1;
                        w_state_nxt = c_WAIT_LINE;
                    end else begin
                        w_state_nxt = c_IDLE;
                    end
                end
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Pattern operand select: a starting line uses word 0 and fresh line/pattern
    always_comb begin
        if (w_line_start) begin
            w_word_idx = 12'd0;
            w_pat_line = PIX_W'(w_line_idx);
            w_pat_sel  = patternSel;
        end else begin
            w_word_idx = r_word_cnt;
            w_pat_line = PIX_W'(currentLine);
            w_pat_sel  = r_pat_sel;
        end
        w_pix_base = PIX_W'(32'(w_word_idx) * PIX_PER_WORD);
    end

    generate
        for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_pix
            logic [PIX_W-1:0] w_p;
            logic [PIX_W-1:0] w_pix;
            assign w_p   = w_pix_base + PIX_W'(gi);
            assign w_pix = (w_pat_sel == 2'd0) ? w_p :
                           (w_pat_sel == 2'd1) ? w_pat_line :
                           (w_pat_sel == 2'd2) ? PIX_W'(frameCnt) :
                                                 {PIX_W{w_p[3] ^ w_pat_line[0]}};
            assign w_pix_word[gi*PIX_W +: PIX_W] = w_pix;
        end
    endgenerate

    // Frame/line counters, config capture and registered outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_line_cnt   <= '0;
            r_word_cnt   <= '0;
            r_line_width <= '0;
            r_start_line <= '0;
            r_num_lines  <= '0;
            r_pat_sel    <= '0;
            pixData      <= '0;
            pixVld       <= 1'b0;
            currentLine  <= '0;
            frameDone    <= 1'b0;
            frameCnt     <= '0;
            ovflCnt      <= '0;
        end else begin
            if (w_arm) begin
                r_line_cnt   <= '0;
                r_line_width <= lineWidth;
                r_start_line <= startLine;
                r_num_lines  <= numLines;
            end else if (w_line_skip || w_line_start) begin
                r_line_cnt <= r_line_cnt + 17'd1;
            end

            if (w_line_start) begin
                r_word_cnt  <= w_emit ? 12'd1 : 12'd0;
                currentLine <= w_line_idx;
                r_pat_sel   <= patternSel;
            end else if (w_emit) begin
                r_word_cnt <= r_word_cnt + 12'd1;
            end

            pixVld <= w_emit;
            if (w_emit) begin
                pixData <= w_pix_word;
            end

            frameDone <= w_frame_done;
            if (w_frame_done) begin
                frameCnt <= frameCnt + 16'd1;
            end

            if ((w_overrun || w_abort) && (ovflCnt != c_OVFL_MAX)) begin
                ovflCnt <= ovflCnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imager_sensor_emulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imager_sensor_emulator
//  Purpose  : Directed self-checking bench for imager_sensor_emulator.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imager_sensor_emulator;

    logic         sys_clk    = 1'b0;
    logic         sys_rst_n  = 1'b0;
    logic         enable     = 1'b0;
    logic         trigMode   = 1'b0;
    logic         XVS        = 1'b1;
    logic         XHS        = 1'b1;
    logic         XTRIG      = 1'b0;
    logic [11:0]  lineWidth  = 12'd0;
    logic [15:0]  startLine  = 16'd0;
    logic [15:0]  numLines   = 16'd0;
    logic [1:0]   patternSel = 2'd0;
    logic [159:0] pixData;
    logic         pixVld;
    logic [12:0]  currentLine;
    logic         frameDone;
    logic [15:0]  frameCnt;
    logic [15:0]  ovflCnt;

    int           n_tests  = 0;
    int           n_fail   = 0;
    int           done_cnt = 0;
    logic [159:0] q_data[$];
    logic [12:0]  q_line[$];

    logic [159:0] w;
    int           nerr;
    int           n0;
    int           n1;

    always #5 sys_clk = ~sys_clk;

    imager_sensor_emulator #(
        .PIX_W        (10),
        .PIX_PER_WORD (16),
        .SYNC_STAGES  (2)
    ) u_dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .enable      (enable),
        .trigMode    (trigMode),
        .XVS         (XVS),
        .XHS         (XHS),
        .XTRIG       (XTRIG),
        .lineWidth   (lineWidth),
        .startLine   (startLine),
        .numLines    (numLines),
        .patternSel  (patternSel),
        .pixData     (pixData),
        .pixVld      (pixVld),
        .currentLine (currentLine),
        .frameDone   (frameDone),
        .frameCnt    (frameCnt),
        .ovflCnt     (ovflCnt)
    );

    // Capture every valid word and count frame completions on the falling edge
    always @(negedge sys_clk) begin
        if (pixVld) begin
            q_data.push_back(pixData);
            q_line.push_back(currentLine);
        end
        if (frameDone) done_cnt++;
    end

    task automatic check_value(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] qd(input int i);
        if (i < q_data.size()) return q_data[i];
        return {160{1'bx}};
    endfunction

    function automatic logic [12:0] ql(input int i);
        if (i < q_line.size()) return q_line[i];
        return {13{1'bx}};
    endfunction

    function automatic logic [159:0] ramp_word(input int wi);
        logic [159:0] r;
        for (int i = 0; i < 16; i++) r[i*10 +: 10] = 10'((wi * 16 + i) % 1024);
        return r;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic hs_pulse(input int period);
        XHS = 1'b0;
        cyc(4);
        XHS = 1'b1;
        cyc(period - 4);
    endtask

    task automatic vs_pulse();
        XVS = 1'b0;
        cyc(4);
        XVS = 1'b1;
        cyc(10);
    endtask

    task automatic trig_pulse();
        XTRIG = 1'b1;
        cyc(4);
        XTRIG = 1'b0;
        cyc(10);
    endtask

    task automatic clear_q();
        q_data.delete();
        q_line.delete();
    endtask

    initial begin
        cyc(3);
        check_value("rst_pixVld",      pixVld,      0);
        check_value("rst_pixData",     pixData,     0);
        check_value("rst_currentLine", currentLine, 0);
        check_value("rst_frameDone",   frameDone,   0);
        check_value("rst_frameCnt",    frameCnt,    0);
        check_value("rst_ovflCnt",     ovflCnt,     0);
        sys_rst_n = 1'b1;
        enable    = 1'b1;
        cyc(5);

        // Basic XVS-armed frame: 2 blanking lines, 3 active lines of 4 words
        trigMode = 1'b0; startLine = 16'd2; numLines = 16'd3; lineWidth = 12'd4; patternSel = 2'd0;
        clear_q();
        vs_pulse();
        repeat (6) hs_pulse(20);
        cyc(10);
        check_value("basic_words", q_data.size(), 12);
        check_value("basic_line_w0", ql(0), 0);
        check_value("basic_line_w4", ql(4), 1);
        check_value("basic_line_w8", ql(8), 2);
        w = qd(1);
        check_value("basic_w1_px0", w[9:0], 16);
        w = qd(3);
        check_value("basic_w3_px15", w[159:150], 63);
        nerr = 0;
        for (int i = 0; i < 12; i++) if (qd(i) !== ramp_word(i % 4)) nerr++;
        check_value("basic_ramp", nerr, 0);
        check_value("basic_done", done_cnt, 1);
        check_value("basic_frameCnt", frameCnt, 1);
        check_value("basic_ovfl", ovflCnt, 0);

        // Trigger arm: XVS ignored, XTRIG rise arms identical frame
        trigMode = 1'b1;
        clear_q();
        vs_pulse();
        repeat (2) hs_pulse(20);
        cyc(10);
        check_value("trig_vs_ignored", q_data.size(), 0);
        trig_pulse();
        repeat (6) hs_pulse(20);
        cyc(10);
        check_value("trig_words", q_data.size(), 12);
        nerr = 0;
        for (int i = 0; i < 12; i++) if (qd(i) !== ramp_word(i % 4)) nerr++;
        check_value("trig_ramp", nerr, 0);
        check_value("trig_line_w8", ql(8), 2);
        check_value("trig_frameCnt", frameCnt, 2);

        // Overrun: 100-word lines cut short by XHS every 40 cycles
        trigMode = 1'b0; startLine = 16'd1; numLines = 16'd2; lineWidth = 12'd100;
        clear_q();
        vs_pulse();
        repeat (4) hs_pulse(40);
        cyc(10);
        n0 = 0; n1 = 0;
        for (int i = 0; i < q_line.size(); i++) begin
            if (q_line[i] == 13'd0) n0++;
            if (q_line[i] == 13'd1) n1++;
        end
        check_value("ovr_line0_bound", (n0 >= 1 && n0 <= 40), 1);
        check_value("ovr_line1_bound", (n1 >= 1 && n1 <= 40), 1);
        check_value("ovr_ovflCnt", ovflCnt, 2);
        check_value("ovr_frameCnt", frameCnt, 3);
        check_value("ovr_done", done_cnt, 3);

        // Abort: second XVS fall in the middle of a line
        startLine = 16'd0; numLines = 16'd2; lineWidth = 12'd100;
        clear_q();
        vs_pulse();
        hs_pulse(20);
        lineWidth = 12'd4;
        XVS = 1'b0;
        cyc(4);
        check_value("abort_vld_drop", pixVld, 0);
        XVS = 1'b1;
        cyc(30);
        check_value("abort_truncated", (q_data.size() < 30), 1);
        check_value("abort_ovflCnt", ovflCnt, 3);
        check_value("abort_no_done", done_cnt, 3);
        clear_q();
        repeat (3) hs_pulse(20);
        cyc(10);
        check_value("abort_next_words", q_data.size(), 8);
        check_value("abort_next_line", ql(7), 1);
        check_value("abort_next_frameCnt", frameCnt, 4);

        // Checker pattern, one word per line
        patternSel = 2'd3; lineWidth = 12'd1; startLine = 16'd0; numLines = 16'd2;
        clear_q();
        vs_pulse();
        repeat (3) hs_pulse(20);
        cyc(10);
        check_value("chk_words", q_data.size(), 2);
        check_value("chk_line0", qd(0), {{80{1'b1}}, {80{1'b0}}});
        check_value("chk_line1", qd(1), {{80{1'b0}}, {80{1'b1}}});

        // Frame pattern: frameCnt is 5 during this frame
        patternSel = 2'd2; numLines = 16'd1;
        clear_q();
        vs_pulse();
        repeat (2) hs_pulse(20);
        cyc(10);
        check_value("frame_pat", qd(0), {16{10'd5}});

        // Line pattern: line 2 word 0 carries 2 in every pixel
        patternSel = 2'd1; startLine = 16'd1; numLines = 16'd3; lineWidth = 12'd2;
        clear_q();
        vs_pulse();
        repeat (5) hs_pulse(20);
        cyc(10);
        check_value("line_pat", qd(4), {16{10'd2}});
        check_value("line_pat_frameCnt", frameCnt, 7);

        // Zero line width: no words but the frame still completes
        patternSel = 2'd0; lineWidth = 12'd0; startLine = 16'd0; numLines = 16'd2;
        clear_q();
        vs_pulse();
        repeat (3) hs_pulse(20);
        cyc(10);
        check_value("lw0_words", q_data.size(), 0);
        check_value("lw0_done", done_cnt, 8);

        // Enable low mid-line
        lineWidth = 12'd100;
        vs_pulse();
        XHS = 1'b0; cyc(4); XHS = 1'b1; cyc(6);
        check_value("en_pre_vld", pixVld, 1);
        enable = 1'b0;
        cyc(1);
        check_value("en_vld_drop", pixVld, 0);
        cyc(2);
        enable = 1'b1;
        clear_q();
        hs_pulse(20);
        cyc(5);
        check_value("en_idle_words", q_data.size(), 0);
        check_value("en_frameCnt_hold", frameCnt, 8);
        check_value("en_ovfl_hold", ovflCnt, 3);

        // Asynchronous reset in the middle of line 1
        vs_pulse();
        hs_pulse(20);
        XHS = 1'b0; cyc(4); XHS = 1'b1; cyc(5);
        check_value("ar_pre_line", currentLine, 1);
        check_value("ar_pre_vld", pixVld, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_value("ar_pixVld",      pixVld,      0);
        check_value("ar_pixData",     pixData,     0);
        check_value("ar_currentLine", currentLine, 0);
        check_value("ar_frameDone",   frameDone,   0);
        check_value("ar_frameCnt",    frameCnt,    0);
        check_value("ar_ovflCnt",     ovflCnt,     0);
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
